// File: rtl/ft601_tx_writer.sv
// ft601_tx_writer: moves words from a first-word-fall-through TX FIFO onto the
// FT601 245-synchronous bus. Each bus tenure is requested from the arbiter and
// bracketed by one driven, idle turnaround cycle on each side. A tenure loads
// at most MAX_BURST words. A word that is not accepted before grant loss is
// held and sent first in the next tenure.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus released, load counter cleared, waiting for data to send
// REQ   | tx_req high, waiting for the arbiter grant
// TURN  | bus driven with strobe idle; output register takes the first word
// BURST | strobing while out_valid; refilling the output register as accepted
// DONE  | bus still driven with strobe idle, request dropped; back to IDLE
module ft601_tx_writer #(
  parameter int MAX_BURST = 256,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] tx_fifo_dout,
  input  logic             tx_fifo_empty,
  output logic             tx_fifo_rden,
  output logic             tx_req,
  input  logic             tx_grant,
  output logic [WIDTH-1:0] usb_data_out,
  output logic             usb_data_oe,
  output logic [3:0]       usb_be,
  output logic             usb_wren_l,
  input  logic             usb_tx_full,
  output logic             tx_busy,
  output logic [31:0]      tx_word_count
);

  localparam int LCW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_TURN,
    S_BURST,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      count_q, count_d;
  logic             pop;
  logic             accept;
  logic             refill;

  // Next-state, output-register load and FIFO pop decisions.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    load_cnt_d  = load_cnt_q;
    data_d      = data_q;
    count_d     = count_q;
    pop         = 1'b0;
    refill      = 1'b0;
    // The strobe is decoded from BURST and out_valid, so this is the
    // word the FT601 takes at this edge.
    accept      = (state_q == S_BURST) && out_valid_q && !usb_tx_full;

    if (accept) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        load_cnt_d = '0;
        // A word held over from a lost grant also needs a new tenure.
        if (!tx_fifo_empty || out_valid_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (tx_grant) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (!out_valid_q && !tx_fifo_empty) begin
          pop         = 1'b1;
          data_d      = tx_fifo_dout;
          out_valid_d = 1'b1;
        end
        // A held word uses the first slot of this tenure.
        load_cnt_d = LCW'(1);
        state_d    = S_BURST;
      end
      S_BURST: begin
        refill = (accept || !out_valid_q) && !tx_fifo_empty &&
                 (load_cnt_q < LCW'(MAX_BURST)) && tx_grant;
        if (refill) begin
          pop         = 1'b1;
          data_d      = tx_fifo_dout;
          out_valid_d = 1'b1;
          load_cnt_d  = load_cnt_q + LCW'(1);
        end else if (accept) begin
          out_valid_d = 1'b0;
        end
        if (!tx_grant || !out_valid_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any held word.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      load_cnt_q  <= '0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      load_cnt_q  <= load_cnt_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end

  // The bus pins decode only from registers. No full/grant path reaches them.
  assign tx_fifo_rden  = pop;
  assign tx_req        = (state_q == S_REQ) || (state_q == S_TURN) || (state_q == S_BURST);
  assign usb_data_oe   = (state_q == S_TURN) || (state_q == S_BURST) || (state_q == S_DONE);
  assign usb_wren_l    = !((state_q == S_BURST) && out_valid_q);
  assign usb_be        = usb_wren_l ? 4'h0 : 4'hF;
  assign usb_data_out  = data_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign tx_word_count = count_q;

endmodule

// File: tb/tb_ft601_tx_writer.sv
// Bench for ft601_tx_writer: FWFT FIFO model, host-side scoreboard of words
// pushed versus words accepted on the bus, and directed bus scenarios.
module tb_ft601_tx_writer;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [31:0] tx_fifo_dout;
  logic        tx_fifo_empty;
  logic        tx_fifo_rden;
  logic        tx_req;
  logic        tx_grant;
  logic [31:0] usb_data_out;
  logic        usb_data_oe;
  logic [3:0]  usb_be;
  logic        usb_wren_l;
  logic        usb_tx_full;
  logic        tx_busy;
  logic [31:0] tx_word_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          ten_q[$];
  logic        pend_pop = 1'b0;
  logic        gate = 1'b0;
  logic        bursty = 1'b0;
  int          acc_count = 0;
  int          ten_cur = 0;
  logic        prev_busy = 1'b0;

  ft601_tx_writer #(.MAX_BURST(256), .WIDTH(32)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .tx_fifo_dout  (tx_fifo_dout),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rden  (tx_fifo_rden),
    .tx_req        (tx_req),
    .tx_grant      (tx_grant),
    .usb_data_out  (usb_data_out),
    .usb_data_oe   (usb_data_oe),
    .usb_be        (usb_be),
    .usb_wren_l    (usb_wren_l),
    .usb_tx_full   (usb_tx_full),
    .tx_busy       (tx_busy),
    .tx_word_count (tx_word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !tx_busy) && n < max) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < max), 32'd1);
  endtask

  task automatic wait_acc(input int target, input string tag);
    int n = 0;
    while (acc_count < target && n < 1000) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk({tag, "_wait"}, 32'(n < 1000), 32'd1);
  endtask

  // FIFO model and bus monitor: pops land at the falling edge after the rising
  // edge that saw rden; bus signals are sampled 2 ns before each rising edge.
  initial begin
    tx_fifo_empty = 1'b1;
    tx_fifo_dout  = 32'h0;
    forever begin
      @(negedge clk);
      if (pend_pop && rst_l && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 1'b0;
      gate = bursty ? !gate : 1'b0;
      #1;
      tx_fifo_empty = gate || (fifo_q.size() == 0);
      tx_fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      #2;
      pend_pop = tx_fifo_rden;
      if (tx_fifo_rden && tx_fifo_empty) chk("pop_while_empty", 32'd1, 32'd0);
      chk("be_vs_strobe", 32'(usb_be), usb_wren_l ? 32'h0 : 32'hF);
      if (!usb_wren_l && !usb_tx_full) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("host_word", usb_data_out, exp_q.pop_front());
        acc_count++;
        ten_cur++;
      end
      if (prev_busy && !tx_busy) begin
        ten_q.push_back(ten_cur);
        ten_cur = 0;
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int base;
    tx_grant    = 1'b1;
    usb_tx_full = 1'b0;

    // Reset values
    #2;
    chk("rst_wren_l", 32'(usb_wren_l), 32'd1);
    chk("rst_oe", 32'(usb_data_oe), 32'd0);
    chk("rst_be", 32'(usb_be), 32'd0);
    chk("rst_data", usb_data_out, 32'd0);
    chk("rst_req", 32'(tx_req), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", tx_word_count, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_l = 1'b1;

    // Single word: request, turnaround, one strobe
    ten_q.delete();
    base = acc_count;
    @(negedge clk);
    push(32'h1C00_00AA);
    #4 chk("single_req_pre", 32'(tx_req), 32'd0);
    @(negedge clk);
    #4 chk("single_req_edge1", 32'(tx_req), 32'd1);
    chk("single_wren_edge1", 32'(usb_wren_l), 32'd1);
    @(negedge clk);
    #4 chk("single_turn_oe", 32'(usb_data_oe), 32'd1);
    chk("single_turn_wren", 32'(usb_wren_l), 32'd1);
    @(negedge clk);
    #4 chk("single_strobe", 32'(usb_wren_l), 32'd0);
    chk("single_data", usb_data_out, 32'h1C00_00AA);
    chk("single_be", 32'(usb_be), 32'hF);
    @(negedge clk);
    #4 chk("single_done_wren", 32'(usb_wren_l), 32'd1);
    chk("single_done_oe", 32'(usb_data_oe), 32'd1);
    wait_idle(50, "single");
    chk("single_acc", 32'(acc_count - base), 32'd1);
    chk("single_wcount", tx_word_count, 32'd1);
    chk("single_tenures", 32'(ten_q.size()), 32'd1);

    // Burst limit: 300 words split 256 + 44
    ten_q.delete();
    base = acc_count;
    @(negedge clk);
    for (int i = 0; i < 300; i++) push(32'hB000_0000 + 32'(i));
    wait_idle(2000, "burst");
    chk("burst_acc", 32'(acc_count - base), 32'd300);
    chk("burst_tenures", 32'(ten_q.size()), 32'd2);
    if (ten_q.size() >= 2) begin
      chk("burst_ten0", 32'(ten_q[0]), 32'd256);
      chk("burst_ten1", 32'(ten_q[1]), 32'd44);
    end
    chk("burst_wcount", tx_word_count, 32'd301);

    // Backpressure: full for 5 cycles while word 10 of 20 is on the bus
    base = acc_count;
    @(negedge clk);
    for (int i = 0; i < 20; i++) push(32'hC000_0000 + 32'(i));
    wait_acc(base + 10, "bp");
    @(negedge clk);
    usb_tx_full = 1'b1;
    held = exp_q.size() > 0 ? exp_q[0] : 32'hDEAD_BEEF;
    chk("bp_held_is_w10", held, 32'hC000_000A);
    repeat (5) begin
      #4;
      chk("bp_stall_data", usb_data_out, held);
      chk("bp_stall_wren", 32'(usb_wren_l), 32'd0);
      chk("bp_stall_rden", 32'(tx_fifo_rden), 32'd0);
      @(negedge clk);
    end
    usb_tx_full = 1'b0;
    #4 chk("bp_resume_wren", 32'(usb_wren_l), 32'd0);
    chk("bp_resume_data", usb_data_out, held);
    wait_idle(200, "bp");
    chk("bp_acc", 32'(acc_count - base), 32'd20);
    chk("bp_wcount", tx_word_count, 32'd321);

    // Grant loss with the word on the bus unaccepted: it leads the next tenure
    ten_q.delete();
    base = acc_count;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(32'hD000_0000 + 32'(i));
    wait_acc(base + 7, "gl");
    @(negedge clk);
    tx_grant    = 1'b0;
    usb_tx_full = 1'b1;
    held = exp_q.size() > 0 ? exp_q[0] : 32'hDEAD_BEEF;
    #4 chk("gl_strobe_kept", 32'(usb_wren_l), 32'd0);
    chk("gl_data", usb_data_out, held);
    @(negedge clk);
    usb_tx_full = 1'b0;
    #4 chk("gl_done_wren", 32'(usb_wren_l), 32'd1);
    chk("gl_done_req", 32'(tx_req), 32'd0);
    repeat (3) @(negedge clk);
    tx_grant = 1'b1;
    wait_idle(200, "gl");
    chk("gl_acc", 32'(acc_count - base), 32'd16);
    chk("gl_tenures", 32'(ten_q.size()), 32'd2);
    if (ten_q.size() >= 2) begin
      chk("gl_ten0", 32'(ten_q[0]), 32'd7);
      chk("gl_ten1", 32'(ten_q[1]), 32'd9);
    end
    chk("gl_wcount", tx_word_count, 32'd337);

    // Reset mid-burst: held word dropped, remaining FIFO words still delivered
    @(negedge clk);
    for (int i = 0; i < 12; i++) push(32'hE000_0000 + 32'(i));
    wait_acc(acc_count + 4, "rst");
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("rstm_wren", 32'(usb_wren_l), 32'd1);
    chk("rstm_oe", 32'(usb_data_oe), 32'd0);
    chk("rstm_count", tx_word_count, 32'd0);
    chk("rstm_be", 32'(usb_be), 32'd0);
    chk("rstm_busy", 32'(tx_busy), 32'd0);
    exp_q = fifo_q;
    acc_count = 0;
    repeat (2) @(negedge clk);
    #1 rst_l = 1'b1;
    wait_idle(200, "rstm");
    chk("rstm_acc", 32'(acc_count), 32'd7);
    chk("rstm_wcount", tx_word_count, 32'd7);

    // Bursty source: empty toggles every cycle
    base = acc_count;
    bursty = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) push(32'hF000_0000 + 32'(i));
    wait_idle(500, "bursty");
    bursty = 1'b0;
    chk("bursty_acc", 32'(acc_count - base), 32'd12);
    chk("bursty_wcount", tx_word_count, 32'd19);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
